slt_share_arbiter: RTL
======================

# slt_share_arbiter

Shares one RV32I set-less-than comparator (SLT/SLTU) between two requesters, e.g. the execute-stage ALU path and a branch/compare helper. Accepts one request at a time through valid/ready handshakes and arbitrates ties round-robin. Computes the 32-bit zero-extended compare result into a register and returns it on the originating requester's response channel, holding it until the requester accepts it.

## Interface
- No parameters; datapath width fixed at 32, type width fixed at 3.
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a compare pending
- req0_ready  out  1  arbiter accepts requester 0 this cycle
- req0_in1  in  32  operand A, requester 0
- req0_in2  in  32  operand B, requester 0
- req0_type  in  3  3'b000 = signed SLT, 3'b001 = unsigned SLTU, others = result 0
- req1_valid, req1_ready, req1_in1, req1_in2, req1_type  same as requester 0, for requester 1
- resp0_valid  out  1  result for requester 0 available
- resp0_ready  in  1  requester 0 takes result
- resp0_data  out  32  result for requester 0: {31'b0, bit}
- resp1_valid, resp1_ready, resp1_data  same as requester 0, for requester 1

## Operation
- States: IDLE (no result held) and RESP (one result held). Reset state is IDLE.
- IDLE grant: only req0_valid -> grant 0. Only req1_valid -> grant 1. Both valid -> grant the requester that is not last_grant. last_grant resets to 1, so requester 0 wins the first tie.
- reqN_ready = (state == IDLE) && grant == N. It is combinational from state, last_grant and both valids. It is never asserted in RESP.
- Handshake (reqN_valid && reqN_ready) at a clock edge:
  - register result, owner = N, last_grant = N; state -> RESP.
  - Result for type 000: signed in1 < in2.
  - Result for type 001: unsigned in1 < in2.
  - Result for any other type: 32'b0.
  - Result bits [31:1] are always 0.
- RESP: respN_valid = 1 for the owner only. respN_data = registered result. The other requester's resp_valid = 0 and its data = 0.
- Owner's respN_valid && respN_ready at an edge -> state IDLE. A new request is not accepted in that same cycle.
- resp_ready from the non-owner is ignored.
- Requesters must keep valid, operands and type stable until ready. valid must not depend on ready. The arbiter does not check this.
- Reset (any time, including in RESP): state -> IDLE, held result discarded, last_grant -> 1, all outputs 0.

## Timing
- Reset values: req0_ready = req1_ready = 0 while rst is high. resp0_valid = resp1_valid = 0. resp0_data = resp1_data = 32'b0.
- Latency: request handshake at edge N -> respN_valid = 1 in the cycle after edge N.
- Throughput: at most one result every 2 cycles (accept edge, then release edge).
- Response stall: resp_valid and resp_data stay constant for every cycle resp_ready is low. There is no timeout.
- Tie fairness: while both requesters stay valid and responses are accepted immediately, grants alternate 0,1,0,1,…
- No combinational path from reqN_* inputs to respN_* outputs. The only combinational path is from req valids to req ready.

## Test plan
- Signed/unsigned compare:
  - req0 in1 = 0xFFFFFFFF, in2 = 0x00000001, type 000 -> resp0_data = 0x00000001.
  - Same operands, type 001 -> 0x00000000.
  - in1 = in2 = 0x80000000, type 000 -> 0x00000000.
  - type 010 -> 0x00000000.
- Latency/handshake: req1 valid in cycle 0 with resp1_ready held high -> req1_ready = 1 in cycle 0; resp1_valid = 1 in cycle 1 only; req1_ready = 1 again in cycle 2.
- Tie arbitration: both valid from reset release, responses accepted immediately -> grant order 0,1,0,1. Each resp carries its own requester's result, e.g. req0 (0x00000005 < 0x00000007, SLTU) = 1 and req1 (0x7FFFFFFF < 0x80000000, SLT) = 0.
- Response stall: hold resp0_ready = 0 for 5 cycles with req1 valid:
  - resp0_valid and resp0_data stay constant.
  - req1_ready stays 0.
  - After resp0_ready rises, req1 is granted in the following cycle.
- Non-owner ready ignored: owner = 0, resp1_ready = 1, resp0_ready = 0 -> state stays RESP and resp0_valid stays 1.
- Reset mid-operation: assert rst asynchronously while in RESP -> resp_valid drops to 0 without waiting for a clock edge, data clears to 0. After release, the next tie grants requester 0.

Source files
------------

// File: rtl/slt_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : slt_share_arbiter
// Brief    : One RV32I SLT/SLTU comparator shared by two requesters, round-robin
// Revision : 1.0 - initial release
// ============================================================================
module slt_share_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,
  input  logic [2:0]  req0_type,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,
  input  logic [2:0]  req1_type,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_data,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_data
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   owner_q, owner_d;
  logic   result_q, result_d;
  logic   grant0, grant1;
  logic   owner_ack;

  function automatic logic slt_bit(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] t);
    case (t)
      3'b000:  slt_bit = $signed(a) < $signed(b);
      3'b001:  slt_bit = a < b;
      default: slt_bit = 1'b0;
    endcase
  endfunction

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant_q);
    grant1     = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = !rst && (state_q == ST_IDLE) && grant0;
    req1_ready = !rst && (state_q == ST_IDLE) && grant1;
    owner_ack  = owner_q ? resp1_ready : resp0_ready;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    result_d     = result_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_ready) begin
          state_d      = ST_RESP;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          result_d     = slt_bit(req0_in1, req0_in2, req0_type);
        end else if (req1_ready) begin
          state_d      = ST_RESP;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          result_d     = slt_bit(req1_in1, req1_in2, req1_type);
        end
      end
      ST_RESP: begin
        // Release takes a full cycle; no new grant in the same cycle.
        if (owner_ack) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      result_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      result_q     <= result_d;
    end
  end

  // Responses depend on flops only, so async reset clears them immediately.
  assign resp0_valid = (state_q == ST_RESP) && !owner_q;
  assign resp1_valid = (state_q == ST_RESP) && owner_q;
  assign resp0_data  = {31'b0, resp0_valid & result_q};
  assign resp1_data  = {31'b0, resp1_valid & result_q};

endmodule
`default_nettype wire
